// File: rtl/nonce_dispatcher_if.sv
// Job request, worker drive/result and status bundle for nonce_dispatcher.
// master = host plus worker array, slave = dispatcher.
interface nonce_dispatcher_if #(
    parameter int NUM_WORKERS = 8
);
    logic                         start;
    logic [7:0][31:0]             midstate;
    logic [2:0][31:0]             header_tail;
    logic [31:0]                  nonce_base;
    logic [31:0]                  nonce_count;
    logic [31:0]                  target;
    logic                         stop_on_hit;

    logic [NUM_WORKERS-1:0]       worker_start;
    logic [NUM_WORKERS-1:0][31:0] worker_nonce;
    logic [2:0][31:0]             worker_in;
    logic [7:0][31:0]             worker_h_in;
    logic [NUM_WORKERS-1:0]       worker_done;
    logic [NUM_WORKERS-1:0][31:0] worker_h_out;

    logic                         busy;
    logic                         done;
    logic                         found;
    logic [31:0]                  found_nonce;
    logic [31:0]                  found_hash;
    logic [31:0]                  hash_count;

    modport master (
        output start, midstate, header_tail, nonce_base, nonce_count, target, stop_on_hit,
        output worker_done, worker_h_out,
        input  worker_start, worker_nonce, worker_in, worker_h_in,
        input  busy, done, found, found_nonce, found_hash, hash_count
    );

    modport slave (
        input  start, midstate, header_tail, nonce_base, nonce_count, target, stop_on_hit,
        input  worker_done, worker_h_out,
        output worker_start, worker_nonce, worker_in, worker_h_in,
        output busy, done, found, found_nonce, found_hash, hash_count
    );
endinterface

// File: rtl/nonce_dispatcher.sv
// Spreads a nonce range over NUM_WORKERS hash workers, one launch per cycle to the lowest free
// worker; done pulses after every in-flight result is collected. start is ignored while busy.
module nonce_dispatcher #(
    parameter int NUM_WORKERS = 8
) (
    input  logic              clk,
    input  logic              reset,
    nonce_dispatcher_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_FINISH  = 2'd3;

    localparam logic [1:0] SL_FREE    = 2'd0;
    localparam logic [1:0] SL_LAUNCH1 = 2'd1;
    localparam logic [1:0] SL_LAUNCH2 = 2'd2;
    localparam logic [1:0] SL_WAIT    = 2'd3;

    logic [1:0]                   state;
    logic [NUM_WORKERS-1:0][1:0]  slot;
    logic [NUM_WORKERS-1:0][31:0] nonce_r;
    logic [7:0][31:0]             midstate_r;
    logic [2:0][31:0]             tail_r;
    logic [31:0]                  target_r;
    logic                         stop_r;
    logic [31:0]                  next_nonce;
    logic [31:0]                  remaining;
    logic                         found_r;
    logic [31:0]                  found_nonce_r;
    logic [31:0]                  found_hash_r;
    logic [31:0]                  hash_count_r;

    logic [NUM_WORKERS-1:0]       free_vec;
    logic [NUM_WORKERS-1:0]       complete_vec;
    logic [NUM_WORKERS-1:0]       hit_vec;
    logic [NUM_WORKERS-1:0]       hit_first;
    logic [NUM_WORKERS-1:0]       launch_vec;
    logic [NUM_WORKERS-1:0]       start_vec;
    logic [4:0]                   complete_cnt;
    logic [32:0]                  hash_sum;
    logic [31:0]                  hit_nonce;
    logic [31:0]                  hit_hash;
    logic                         hit_any;
    logic                         stop_now;
    logic                         launch_ok;
    logic                         launch_any;
    logic                         accept;

    assign accept = (state == ST_IDLE) && bus.start;

    always_comb begin
        free_vec     = '0;
        complete_vec = '0;
        hit_vec      = '0;
        start_vec    = '0;
        complete_cnt = '0;
        for (int j = 0; j < NUM_WORKERS; j++) begin
            free_vec[j]     = (slot[j] == SL_FREE);
            start_vec[j]    = (slot[j] == SL_LAUNCH1) || (slot[j] == SL_LAUNCH2);
            complete_vec[j] = (slot[j] == SL_WAIT) && bus.worker_done[j];
            hit_vec[j]      = complete_vec[j] && (bus.worker_h_out[j] <= target_r);
            complete_cnt    = complete_cnt + 5'(complete_vec[j]);
        end
    end

    // x & -x isolates the lowest set bit: lowest-index priority for both launch and hit capture.
    assign hit_any    = |hit_vec;
    assign hit_first  = hit_vec & (~hit_vec + NUM_WORKERS'(1));
    assign stop_now   = stop_r && (found_r || hit_any);
    assign launch_ok  = (state == ST_RUN) && (remaining != 32'd0) && !stop_now;
    assign launch_vec = launch_ok ? (free_vec & (~free_vec + NUM_WORKERS'(1))) : '0;
    assign launch_any = |launch_vec;
    assign hash_sum   = {1'b0, hash_count_r} + {28'b0, complete_cnt};

    always_comb begin
        hit_nonce = '0;
        hit_hash  = '0;
        for (int j = 0; j < NUM_WORKERS; j++) begin
            if (hit_first[j]) begin
                hit_nonce = nonce_r[j];
                hit_hash  = bus.worker_h_out[j];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            midstate_r <= '0;
            tail_r     <= '0;
            target_r   <= '0;
            stop_r     <= 1'b0;
            next_nonce <= '0;
            remaining  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state      <= ST_RUN;
                        midstate_r <= bus.midstate;
                        tail_r     <= bus.header_tail;
                        target_r   <= bus.target;
                        stop_r     <= bus.stop_on_hit;
                        next_nonce <= bus.nonce_base;
                        remaining  <= bus.nonce_count;
                    end
                end
                ST_RUN: begin
                    if ((remaining == 32'd0) || stop_now) begin
                        state <= ST_DRAIN;
                    end else if (launch_any) begin
                        next_nonce <= next_nonce + 32'd1;
                        remaining  <= remaining - 32'd1;
                    end
                end
                ST_DRAIN: begin
                    if (&free_vec) state <= ST_FINISH;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot    <= '0;
            nonce_r <= '0;
        end else begin
            for (int j = 0; j < NUM_WORKERS; j++) begin
                case (slot[j])
                    SL_FREE: begin
                        if (launch_vec[j]) begin
                            slot[j]    <= SL_LAUNCH1;
                            nonce_r[j] <= next_nonce;
                        end
                    end
                    SL_LAUNCH1: slot[j] <= SL_LAUNCH2;
                    SL_LAUNCH2: slot[j] <= SL_WAIT;
                    default: begin
                        if (bus.worker_done[j]) slot[j] <= SL_FREE;
                    end
                endcase
            end
        end
    end

    // Results survive FINISH/IDLE and are only cleared by the next accepted job.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            found_r       <= 1'b0;
            found_nonce_r <= '0;
            found_hash_r  <= '0;
            hash_count_r  <= '0;
        end else if (accept) begin
            found_r       <= 1'b0;
            found_nonce_r <= '0;
            found_hash_r  <= '0;
            hash_count_r  <= '0;
        end else begin
            if (complete_cnt != 5'd0) begin
                hash_count_r <= hash_sum[32] ? 32'hFFFF_FFFF : hash_sum[31:0];
            end
            if (hit_any && !found_r) begin
                found_r       <= 1'b1;
                found_nonce_r <= hit_nonce;
                found_hash_r  <= hit_hash;
            end
        end
    end

    assign bus.worker_start = start_vec;
    assign bus.worker_nonce = nonce_r;
    assign bus.worker_in    = tail_r;
    assign bus.worker_h_in  = midstate_r;
    assign bus.busy         = (state != ST_IDLE);
    assign bus.done         = (state == ST_FINISH);
    assign bus.found        = found_r;
    assign bus.found_nonce  = found_nonce_r;
    assign bus.found_hash   = found_hash_r;
    assign bus.hash_count   = hash_count_r;
endmodule

// File: doc/nonce_dispatcher.md
NONCE_DISPATCHER -- requirements
Module: nonce_dispatcher

Interface
REQ-001 SHALL have parameter NUM_WORKERS, default 8, meaning number of attached double-SHA-256 workers (1..16).
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  in  1  one-cycle job request, sampled only when busy=0.
REQ-005 SHALL have port midstate  in  32x8  first-block hash state, forwarded to workers.
REQ-006 SHALL have port header_tail  in  32x3  header words 16..18, forwarded to workers.
REQ-007 SHALL have port nonce_base  in  32  first nonce of job.
REQ-008 SHALL have port nonce_count  in  32  number of nonces to try.
REQ-009 SHALL have port target  in  32  hit threshold on final hash word 0.
REQ-010 SHALL have port stop_on_hit  in  1  end job at first hit when 1.
REQ-011 SHALL have ports worker_start out NUM_WORKERS, worker_nonce out 32xNUM_WORKERS, worker_in out 32x3, worker_h_in out 32x8: worker drive.
REQ-012 SHALL have ports worker_done in NUM_WORKERS, worker_h_out in 32xNUM_WORKERS: worker result.
REQ-013 SHALL have outputs busy 1, done 1 (one-cycle pulse), found 1, found_nonce 32, found_hash 32, hash_count 32.

Function
REQ-014 SHALL register midstate, header_tail, target, stop_on_hit, nonce_base and nonce_count on accepted start; worker_in/worker_h_in driven from these registers.
REQ-015 SHALL keep top FSM IDLE -> RUN -> DRAIN -> FINISH -> IDLE.
REQ-016 IDLE: busy=0; start moves to RUN next cycle, clears found, found_nonce, found_hash, hash_count.
REQ-017 SHALL keep per-worker slot FSM FREE -> LAUNCH1 -> LAUNCH2 -> WAIT -> FREE.
REQ-018 worker_start[j] SHALL be 1 exactly in LAUNCH1 and LAUNCH2 (two cycles), worker_nonce[j] held constant from LAUNCH1 until slot returns to FREE.
REQ-019 worker_done[j] SHALL be ignored outside WAIT; in WAIT, worker_done[j]=1 completes slot (result sampled that cycle, slot FREE next cycle).
REQ-020 In RUN, at most one launch per cycle, to lowest-index FREE slot, while remaining>0.
REQ-021 Each launch SHALL assign next_nonce, then next_nonce+1 modulo 2^32 (0xFFFFFFFF wraps to 0), remaining-1.
REQ-022 Each completion SHALL increment hash_count by 1 (saturating at 0xFFFFFFFF).
REQ-023 Hit: worker_h_out[j] <= target, unsigned.
REQ-024 First hit of job SHALL latch found=1, found_nonce, found_hash; later hits SHALL NOT overwrite.
REQ-025 Simultaneous hits SHALL record lowest worker index.
REQ-026 RUN -> DRAIN when remaining=0, or when found=1 and stop_on_hit=1; DRAIN launches nothing.
REQ-027 DRAIN -> FINISH when all slots FREE; in-flight results still counted and may set found.
REQ-028 FINISH SHALL pulse done=1 one cycle, then IDLE; found/found_nonce/found_hash/hash_count held until next accepted start.
REQ-029 nonce_count=0 SHALL give RUN -> DRAIN -> FINISH with no launch, done 3 cycles after start, found=0.
REQ-030 start while busy=1 SHALL be ignored, no effect on registers.
REQ-031 busy SHALL be 1 in RUN, DRAIN, FINISH.

Reset
REQ-032 reset=1 SHALL immediately force IDLE, all slots FREE, worker_start=0, busy=0, done=0, found=0, found_nonce=0, found_hash=0, hash_count=0, worker_nonce=0.
REQ-033 reset mid-job SHALL abandon in-flight results; first start after release begins a clean job.

Verification
REQ-034 nonce_base=0x10, count=3, NUM_WORKERS=8, target=0 with no hit -> workers 0,1,2 get nonces 0x10,0x11,0x12 on consecutive cycles; done once; hash_count=3; found=0.
REQ-035 count=20, NUM_WORKERS=4, model workers returning h_out=0xFFFFFFFF except nonce base+13 returning 0x00000005, target=0x10, stop_on_hit=0 -> found_nonce=base+13, found_hash=5, hash_count=20.
REQ-036 Same with stop_on_hit=1 -> no launch after hit, in-flight drained, hash_count = launches made, found_nonce=base+13.
REQ-037 nonce_base=0xFFFFFFFE, count=4 -> nonces FFFFFFFE, FFFFFFFF, 0, 1 issued.
REQ-038 Workers 1 and 3 finish same cycle, both hit -> found_nonce is worker 1's nonce.
REQ-039 reset pulsed during RUN, then start with count=1 -> all outputs 0 after reset; new job completes with hash_count=1; start asserted during busy ignored.
